// File: rtl/fft_framer_pkg.sv
// rtl/fft_framer_pkg.sv - shared types, error codes and frame-length rule for the FFT framer
package fft_framer_pkg;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_PAD = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_PAD
  } state_t;

  // A frame length is usable only if it is a power of two inside [min_pts, max_pts].
  function automatic logic legal_pts(input logic [31:0] v, input logic [31:0] min_pts,
                                     input logic [31:0] max_pts);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0) && (v >= min_pts) && (v <= max_pts);
  endfunction

endpackage

// File: rtl/fft_stream_framer_if.sv
// rtl/fft_stream_framer_if.sv - sample input and framed output handshakes of the FFT framer
interface fft_stream_framer_if #(
  parameter int DATA_W = 18,
  parameter int PTS_W  = 11,
  parameter int CH_W   = 2
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_real;
  logic signed [DATA_W-1:0] in_imag;
  logic [CH_W-1:0]          in_chan;

  logic                     out_valid;
  logic                     out_ready;
  logic                     out_sop;
  logic                     out_eop;
  logic [1:0]               out_error;
  logic signed [DATA_W-1:0] out_real;
  logic signed [DATA_W-1:0] out_imag;
  logic [PTS_W-1:0]         out_fftpts;
  logic                     out_inverse;
  logic [CH_W-1:0]          out_chan;

  modport slave (
    input  in_valid, in_real, in_imag, in_chan, out_ready,
    output in_ready, out_valid, out_sop, out_eop, out_error, out_real, out_imag,
           out_fftpts, out_inverse, out_chan
  );

  modport master (
    output in_valid, in_real, in_imag, in_chan, out_ready,
    input  in_ready, out_valid, out_sop, out_eop, out_error, out_real, out_imag,
           out_fftpts, out_inverse, out_chan
  );
endinterface

// File: rtl/fft_framer_fifo.sv
// rtl/fft_framer_fifo.sv - synchronous FIFO with reset-cleared storage and full/empty/count
// The head entry is read straight from storage, so a word written in cycle N is visible in N+1.
module fft_framer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end
endmodule

// File: rtl/fft_stream_framer.sv
// rtl/fft_stream_framer.sv - cuts a complex sample stream into power-of-two FFT frames
// Short frames (flush or channel switch) are zero-padded and flagged; illegal lengths are dropped.
module fft_stream_framer
  import fft_framer_pkg::*;
#(
  parameter int DATA_W     = 18,
  parameter int PTS_W      = 11,
  parameter int MIN_PTS    = 8,
  parameter int CH_W       = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PTS_W-1:0]   cfg_fftpts,
  input  logic               cfg_inverse,
  input  logic               flush,
  fft_stream_framer_if.slave bus,
  output logic [15:0]        frame_count,
  output logic [15:0]        drop_count
);
  localparam int MAX_PTS = 1 << (PTS_W - 1);
  localparam int WORD_W  = 5 + 2 * DATA_W + PTS_W + CH_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  state_t                   state;
  logic [PTS_W-1:0]         idx;
  logic [PTS_W-1:0]         pts_q;
  logic                     inv_q;
  logic [CH_W-1:0]          chan_q;
  logic                     run_q;

  logic                     chan_mismatch;
  logic                     cfg_legal;
  logic                     in_fire;
  logic                     last;

  logic                     wr_en;
  logic                     w_sop;
  logic                     w_eop;
  logic [1:0]               w_err;
  logic signed [DATA_W-1:0] w_real;
  logic signed [DATA_W-1:0] w_imag;
  logic [PTS_W-1:0]         w_pts;
  logic                     w_inv;
  logic [CH_W-1:0]          w_chan;
  logic [WORD_W-1:0]        wr_word;
  logic [WORD_W-1:0]        rd_word;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [CNT_W-1:0]         fifo_count;

  // run_q keeps in_ready low through reset and releases it the cycle after.
  assign chan_mismatch = (state == ST_FILL) && bus.in_valid && (bus.in_chan != chan_q);
  assign cfg_legal     = legal_pts(32'(cfg_fftpts), 32'(MIN_PTS), 32'(MAX_PTS));
  assign bus.in_ready  = run_q && (fifo_count != CNT_W'(FIFO_DEPTH)) && (state != ST_PAD)
                         && !chan_mismatch;
  assign in_fire       = bus.in_valid && bus.in_ready;
  assign last          = (idx == pts_q - PTS_W'(1));

  always_comb begin
    wr_en  = 1'b0;
    w_sop  = 1'b0;
    w_eop  = 1'b0;
    w_err  = ERR_OK;
    w_real = bus.in_real;
    w_imag = bus.in_imag;
    w_pts  = pts_q;
    w_inv  = inv_q;
    w_chan = chan_q;
    case (state)
      ST_IDLE: begin
        if (in_fire && cfg_legal) begin
          wr_en  = 1'b1;
          w_sop  = 1'b1;
          w_pts  = cfg_fftpts;
          w_inv  = cfg_inverse;
          w_chan = bus.in_chan;
        end
      end
      ST_FILL: begin
        if (in_fire) begin
          wr_en = 1'b1;
          w_eop = last;
        end
      end
      ST_PAD: begin
        if (!fifo_full) begin
          wr_en  = 1'b1;
          w_eop  = last;
          w_err  = ERR_PAD;
          w_real = '0;
          w_imag = '0;
        end
      end
      default: ;
    endcase
  end

  assign wr_word = {w_sop, w_eop, w_err, w_real, w_imag, w_pts, w_inv, w_chan};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      pts_q       <= '0;
      inv_q       <= 1'b0;
      chan_q      <= '0;
      run_q       <= 1'b0;
      frame_count <= '0;
      drop_count  <= '0;
    end else begin
      run_q <= 1'b1;
      if (wr_en) begin
        idx <= w_eop ? '0 : idx + PTS_W'(1);
        if (w_eop) frame_count <= frame_count + 16'd1;
      end
      case (state)
        ST_IDLE: begin
          if (in_fire) begin
            if (cfg_legal) begin
              pts_q  <= cfg_fftpts;
              inv_q  <= cfg_inverse;
              chan_q <= bus.in_chan;
              state  <= ST_FILL;
            end else if (drop_count != 16'hFFFF) begin
              drop_count <= drop_count + 16'd1;
            end
          end
        end
        ST_FILL: begin
          // A completing sample wins over a simultaneous flush: nothing is left to pad.
          if (wr_en && w_eop) state <= ST_IDLE;
          else if (flush || chan_mismatch) state <= ST_PAD;
        end
        ST_PAD: begin
          if (wr_en && w_eop) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fft_framer_fifo #(
    .WIDTH(WORD_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_data(wr_word),
    .rd_en  (bus.out_ready),
    .rd_data(rd_word),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign bus.out_valid = !fifo_empty;
  assign {bus.out_sop, bus.out_eop, bus.out_error, bus.out_real, bus.out_imag,
          bus.out_fftpts, bus.out_inverse, bus.out_chan} = rd_word;
endmodule

// File: tb/tb_fft_stream_framer.sv
// tb/tb_fft_stream_framer.sv - randomized bench for fft_stream_framer with a frame-level model
module tb_fft_stream_framer;
  localparam int DATA_W = 18;
  localparam int PTS_W  = 11;
  localparam int CH_W   = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [PTS_W-1:0] cfg_fftpts = '0;
  logic             cfg_inverse = 1'b0;
  logic             flush = 1'b0;
  logic [15:0]      frame_count;
  logic [15:0]      drop_count;

  fft_stream_framer_if #(.DATA_W(DATA_W), .PTS_W(PTS_W), .CH_W(CH_W)) bus ();

  fft_stream_framer #(
    .DATA_W(DATA_W), .PTS_W(PTS_W), .MIN_PTS(8), .CH_W(CH_W), .FIFO_DEPTH(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_fftpts (cfg_fftpts),
    .cfg_inverse(cfg_inverse),
    .flush      (flush),
    .bus        (bus),
    .frame_count(frame_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  bit          m_open = 0;
  int          m_pts, m_cnt;
  logic        m_inv;
  logic [1:0]  m_chan;
  logic [15:0] m_frames = 0;
  logic [15:0] m_drops = 0;
  int          pad_seen = 0;
  int          acc_count = 0;
  bit          done_rand;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit legal(input int v);
    return v inside {8, 16, 32, 64, 128, 256, 512, 1024};
  endfunction

  function automatic void push(input bit sop, input bit eop, input logic [1:0] err,
                               input logic [17:0] re, input logic [17:0] im);
    exp_q.push_back({10'd0, sop, eop, err, re, im, 11'(m_pts), m_inv, m_chan});
  endfunction

  function automatic void pad_frame();
    while (m_cnt < m_pts) begin
      m_cnt++;
      push(1'b0, m_cnt == m_pts, 2'b01, 18'd0, 18'd0);
    end
    m_frames++;
    m_open = 0;
  endfunction

  // Monitor and reference model: evaluated half a cycle before each active edge.
  always @(negedge clk) begin
    logic [63:0] got, exp;
    bit fire;
    if (reset) begin
      exp_q.delete();
      m_open = 0; m_frames = 0; m_drops = 0; pad_seen = 0; acc_count = 0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_word", 64'(bus.out_valid), 64'(0));
        end else begin
          got = {10'd0, bus.out_sop, bus.out_eop, bus.out_error, bus.out_real, bus.out_imag,
                 bus.out_fftpts, bus.out_inverse, bus.out_chan};
          exp = exp_q.pop_front();
          check("word", got, exp);
          if (bus.out_error == 2'b01) pad_seen++;
        end
      end
      fire = bus.in_valid && bus.in_ready;
      if (fire) acc_count++;
      if (!m_open) begin
        if (fire) begin
          if (legal(int'(cfg_fftpts))) begin
            m_open = 1; m_pts = int'(cfg_fftpts); m_inv = cfg_inverse; m_chan = bus.in_chan;
            m_cnt = 1;
            push(1'b1, 1'b0, 2'b00, bus.in_real, bus.in_imag);
          end else if (m_drops != 16'hFFFF) begin
            m_drops++;
          end
        end
      end else begin
        if (fire) begin
          m_cnt++;
          push(1'b0, m_cnt == m_pts, 2'b00, bus.in_real, bus.in_imag);
          if (m_cnt == m_pts) begin m_frames++; m_open = 0; end
        end
        if (m_open && (flush || (bus.in_valid && bus.in_chan != m_chan))) pad_frame();
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.in_valid = 1'b0; flush = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
  endtask

  task automatic send(input logic [1:0] ch);
    int n;
    bit ok;
    n = 0; ok = 0;
    bus.in_valid = 1'b1; bus.in_chan = ch;
    bus.in_real = 18'($urandom); bus.in_imag = 18'($urandom);
    while (!ok && n < 3000) begin
      @(negedge clk);
      ok = bus.in_ready;
      n++;
    end
    if (!ok) check("send_ready", 64'(bus.in_ready), 64'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 20000) begin
      step();
      n++;
    end
    check("drain_left", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_real = '0; bus.in_imag = '0; bus.in_chan = '0;
    bus.out_ready = 1'b1;

    // Reset values
    repeat (3) step();
    check("rst_valid", 64'(bus.out_valid), 64'(0));
    check("rst_sop", 64'(bus.out_sop), 64'(0));
    check("rst_eop", 64'(bus.out_eop), 64'(0));
    check("rst_error", 64'(bus.out_error), 64'(0));
    check("rst_real", 64'(bus.out_real), 64'(0));
    check("rst_imag", 64'(bus.out_imag), 64'(0));
    check("rst_fftpts", 64'(bus.out_fftpts), 64'(0));
    check("rst_inverse", 64'(bus.out_inverse), 64'(0));
    check("rst_chan", 64'(bus.out_chan), 64'(0));
    check("rst_frames", 64'(frame_count), 64'(0));
    check("rst_drops", 64'(drop_count), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    reset = 1'b0;
    step();
    check("ready_after_rst", 64'(bus.in_ready), 64'(1));

    // Two back-to-back 16-point frames, first-word latency
    cfg_fftpts = 11'd16; cfg_inverse = 1'b1;
    check("idle_valid", 64'(bus.out_valid), 64'(0));
    send(2'd0);
    check("latency_valid", 64'(bus.out_valid), 64'(1));
    check("latency_sop", 64'(bus.out_sop), 64'(1));
    for (int i = 1; i < 32; i++) send(2'd0);
    drain();
    check("a_frames", 64'(frame_count), 64'(2));
    check("a_drops", 64'(drop_count), 64'(0));

    // Illegal length dropped, then a minimum-length frame
    do_reset();
    cfg_fftpts = 11'd12; cfg_inverse = 1'b0;
    for (int i = 0; i < 5; i++) send(2'd0);
    check("b_drops", 64'(drop_count), 64'(5));
    cfg_fftpts = 11'd8;
    for (int i = 0; i < 8; i++) send(2'd0);
    drain();
    check("b_frames", 64'(frame_count), 64'(1));

    // Channel switch after 5 of 16 pads 11 words; held sample opens the next frame
    do_reset();
    cfg_fftpts = 11'd16;
    for (int i = 0; i < 5; i++) send(2'd0);
    send(2'd1);
    drain();
    check("c_pad_words", 64'(pad_seen), 64'(11));
    check("c_frames", 64'(frame_count), 64'(1));

    // Flush after 3 of 8, then flush while idle
    do_reset();
    cfg_fftpts = 11'd8;
    for (int i = 0; i < 3; i++) send(2'd2);
    pulse_flush();
    drain();
    check("d_pad_words", 64'(pad_seen), 64'(5));
    check("d_frames", 64'(frame_count), 64'(1));
    pulse_flush();
    repeat (4) step();
    check("d_idle_flush_valid", 64'(bus.out_valid), 64'(0));
    check("d_idle_flush_frames", 64'(frame_count), 64'(1));

    // Output stalled: FIFO fills after 8 accepts, nothing lost on release
    do_reset();
    cfg_fftpts = 11'd16;
    bus.out_ready = 1'b0;
    fork
      for (int i = 0; i < 16; i++) send(2'd3);
      begin
        repeat (20) @(posedge clk);
        #1;
        check("e_accepts", 64'(acc_count), 64'(8));
        check("e_in_ready", 64'(bus.in_ready), 64'(0));
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("e_frames", 64'(frame_count), 64'(1));

    // Reset mid-frame at idx 7, then a clean frame
    do_reset();
    cfg_fftpts = 11'd16;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(2'd1);
    reset = 1'b1;
    step();
    check("f_valid", 64'(bus.out_valid), 64'(0));
    check("f_sop", 64'(bus.out_sop), 64'(0));
    check("f_real", 64'(bus.out_real), 64'(0));
    check("f_frames", 64'(frame_count), 64'(0));
    check("f_in_ready", 64'(bus.in_ready), 64'(0));
    reset = 1'b0;
    bus.out_ready = 1'b1;
    step();
    for (int i = 0; i < 16; i++) send(2'd0);
    drain();
    check("f_frames_after", 64'(frame_count), 64'(1));

    // Randomized: two 1024-point frames, then mixed lengths, flushes and channel switches
    do_reset();
    cfg_fftpts = 11'd1024;
    done_rand = 0;
    fork
      begin
        logic [1:0] cur_ch;
        int opts[8];
        opts = '{1024, 8, 16, 64, 12, 0, 4, 1536};
        cur_ch = 2'd0;
        for (int i = 0; i < 2048; i++) begin
          if ($urandom_range(0, 19) == 0) step();
          send(cur_ch);
        end
        for (int i = 0; i < 1500; i++) begin
          int r;
          r = $urandom_range(0, 199);
          if (r < 2) pulse_flush();
          else if (r < 5) begin
            cfg_fftpts = 11'(opts[$urandom_range(0, 7)]);
            cfg_inverse = 1'($urandom);
          end else if (r < 7) cur_ch = 2'($urandom);
          else if (r < 13) step();
          else send(cur_ch);
        end
        done_rand = 1;
      end
      begin
        while (!done_rand) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();
    check("r_frames", 64'(frame_count), 64'(m_frames));
    check("r_drops", 64'(drop_count), 64'(m_drops));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
